pipe_hazard_ctrl: RTL

- Parametrised stall/flush merge unit for the multistage pipeline; replaces the fixed two- and three-input OR merges of stall, flush and block requests.
- Accepts N_STALL stall sources and N_FLUSH flush sources, each tagged with a pipeline-register level.
- Adds multi-cycle stall hold counters and a sticky exception block.
- Drives per-register hold and flush vectors for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_ctrl_if.sv | 35 +++
 rtl/pipe_hazard_ctrl_stall_timer.sv | 45 ++++
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard control slice: register
// indices, default field widths and the level clamp helper.
package pipe_ctrl_pkg;

  // Pipeline register indices in the hold/flush vectors
  localparam int unsigned PREG_PC    = 32'd0;
  localparam int unsigned PREG_IFID  = 32'd1;
  localparam int unsigned PREG_IDEX  = 32'd2;
  localparam int unsigned PREG_EXMEM = 32'd3;
  localparam int unsigned PREG_MEMWB = 32'd4;

  // Default widths of the level and stall length fields
  localparam int unsigned LVL_W_DEF = 32'd3;
  localparam int unsigned LEN_W_DEF = 32'd4;

  // Levels that point past the last controlled register select the last one
  function automatic int unsigned clamp_lvl(input int unsigned lvl,
                                            input int unsigned n_preg);
    return (lvl >= n_preg) ? (n_preg - 32'd1) : lvl;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Request/control bundle between the pipeline hazard sources and the
// stall/flush merge unit.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned N_STALL = 32'd2,
  parameter int unsigned N_FLUSH = 32'd2,
  parameter int unsigned N_PREG  = 32'd5,
  parameter int unsigned LVL_W   = 32'd3,
  parameter int unsigned LEN_W   = 32'd4
);
  logic [N_STALL-1:0]       stall_req;
  logic [N_STALL*LVL_W-1:0] stall_lvl;
  logic [N_STALL*LEN_W-1:0] stall_len;
  logic [N_FLUSH-1:0]       flush_req;
  logic [N_FLUSH*LVL_W-1:0] flush_lvl;
  logic                     blk_set;
  logic                     blk_clr;
  logic [N_PREG-1:0]        preg_hold;
  logic [N_PREG-1:0]        preg_flush;
  logic                     pc_stall;
  logic                     busy;

  // Request side: hazard sources drive requests and observe controls
  modport master (
    output stall_req, stall_lvl, stall_len, flush_req, flush_lvl,
           blk_set, blk_clr,
    input  preg_hold, preg_flush, pc_stall, busy
  );

  // Merge unit side
  modport slave (
    input  stall_req, stall_lvl, stall_len, flush_req, flush_lvl,
           blk_set, blk_clr,
    output preg_hold, preg_flush, pc_stall, busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl_stall_timer.sv
// Per-source stall hold counter. A request longer than one cycle loads the
// remaining length; the count runs down without re-trigger and is cancelled
// when a flush reaches the level this source is holding.
module pipe_stall_timer #(
  parameter int unsigned LVL_W = 32'd3,
  parameter int unsigned LEN_W = 32'd4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [LEN_W-1:0] len,
  input  logic [LVL_W-1:0] lvl,
  input  logic             flush_any,
  input  logic [LVL_W-1:0] flush_lvl,
  output logic             active,
  output logic             cnt_nz
);

  logic [LEN_W-1:0] cnt_r;
  logic             cancel_s;

  // A flush at or beyond the held level squashes the stalled instruction
  always_comb begin
    cancel_s = flush_any && (flush_lvl >= lvl);
  end

  // Hold counter: cancel, then count down, then load on a new long request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {LEN_W{1'b0}};
    end else if (cancel_s) begin
      cnt_r <= {LEN_W{1'b0}};
    end else if (cnt_r != {LEN_W{1'b0}}) begin
      cnt_r <= cnt_r - {{(LEN_W-1){1'b0}}, 1'b1};
    end else if (req && (len > {{(LEN_W-1){1'b0}}, 1'b1})) begin
      cnt_r <= len - {{(LEN_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt_nz = (cnt_r != {LEN_W{1'b0}});
  assign active = req | cnt_nz;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush merge unit: reduces any number of tagged stall and flush
// requests to per-register hold and flush vectors, with multi-cycle stall
// timers and a sticky exception block.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned N_STALL = 32'd2,
  parameter int unsigned N_FLUSH = 32'd2,
  parameter int unsigned N_PREG  = 32'd5,
  parameter int unsigned LVL_W   = LVL_W_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  logic [LVL_W-1:0]  st_lvl_s [N_STALL];
  logic [LVL_W-1:0]  fl_lvl_s [N_FLUSH];
  logic [N_STALL-1:0] active_s;
  logic [N_STALL-1:0] cnt_nz_s;
  logic               flush_any_s;
  logic [LVL_W-1:0]   f_lvl_s;
  logic               stall_s;
  logic [LVL_W-1:0]   s_lvl_s;
  logic               blk_r;
  logic [N_PREG-1:0]  hold_s;
  logic [N_PREG-1:0]  flush_s;

  // Clamp every level field to the last controlled register
  always_comb begin
    for (int i = 0; i < int'(N_STALL); i++) begin
      st_lvl_s[i] = LVL_W'(clamp_lvl(32'(bus.stall_lvl[i*LVL_W +: LVL_W]), N_PREG));
    end
    for (int j = 0; j < int'(N_FLUSH); j++) begin
      fl_lvl_s[j] = LVL_W'(clamp_lvl(32'(bus.flush_lvl[j*LVL_W +: LVL_W]), N_PREG));
    end
  end

  // Deepest flushed register over all asserted flush sources
  always_comb begin
    flush_any_s = 1'b0;
    f_lvl_s     = {LVL_W{1'b0}};
    for (int j = 0; j < int'(N_FLUSH); j++) begin
      if (bus.flush_req[j]) begin
        flush_any_s = 1'b1;
        f_lvl_s     = (fl_lvl_s[j] > f_lvl_s) ? fl_lvl_s[j] : f_lvl_s;
      end else begin
        f_lvl_s     = f_lvl_s;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < int'(N_STALL); gi++) begin : g_timer
      pipe_stall_timer #(
        .LVL_W (LVL_W),
        .LEN_W (LEN_W)
      ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.stall_req[gi]),
        .len       (bus.stall_len[gi*LEN_W +: LEN_W]),
        .lvl       (st_lvl_s[gi]),
        .flush_any (flush_any_s),
        .flush_lvl (f_lvl_s),
        .active    (active_s[gi]),
        .cnt_nz    (cnt_nz_s[gi])
      );
    end
  endgenerate

  // Deepest held register over active stall sources; the block holds at least IF/ID
  always_comb begin
    stall_s = 1'b0;
    s_lvl_s = {LVL_W{1'b0}};
    for (int i = 0; i < int'(N_STALL); i++) begin
      if (active_s[i]) begin
        stall_s = 1'b1;
        s_lvl_s = (st_lvl_s[i] > s_lvl_s) ? st_lvl_s[i] : s_lvl_s;
      end else begin
        s_lvl_s = s_lvl_s;
      end
    end
    if (blk_r) begin
      stall_s = 1'b1;
      s_lvl_s = (s_lvl_s < LVL_W'(PREG_IFID)) ? LVL_W'(PREG_IFID) : s_lvl_s;
    end else begin
      s_lvl_s = s_lvl_s;
    end
  end

  // Sticky exception block; set wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_r <= 1'b0;
    end else if (bus.blk_set) begin
      blk_r <= 1'b1;
    end else if (bus.blk_clr) begin
      blk_r <= 1'b0;
    end else begin
      blk_r <= blk_r;
    end
  end

  // Per-register hold/flush: flush range, bubble behind the stall, reset override
  always_comb begin
    hold_s  = {N_PREG{1'b0}};
    flush_s = {N_PREG{1'b0}};
    if (!rst_n) begin
      flush_s = {{(N_PREG-1){1'b1}}, 1'b0};
      hold_s  = {N_PREG{1'b0}};
    end else begin
      for (int k = 0; k < int'(N_PREG); k++) begin
        flush_s[k] = (flush_any_s && (k >= 1) && (k <= int'(f_lvl_s))) ||
                     (stall_s && (k == int'(s_lvl_s) + 1));
        hold_s[k]  = stall_s && (k <= int'(s_lvl_s)) && !flush_s[k];
      end
      if (flush_any_s) begin
        hold_s[PREG_PC] = 1'b0;
      end else begin
        hold_s[PREG_PC] = hold_s[PREG_PC];
      end
    end
  end

  assign bus.preg_hold  = hold_s;
  assign bus.preg_flush = flush_s;
  assign bus.pc_stall   = hold_s[PREG_PC];
  assign bus.busy       = rst_n && ((|cnt_nz_s) || blk_r);

endmodule
